// File: rtl/dfu_boot_ctrl.sv
// Bootloader supervisor: sequences USB core reset and pull-up, runs the auto-boot timer,
// merges detach / timeout / button triggers into a sticky boot request and drives status LEDs.
module dfu_boot_ctrl #(
  parameter int CLK_HZ          = 12000000,
  parameter int RESET_CYCLES    = 65535,
  parameter int AUTOBOOT_MS     = 5000,
  parameter int N_LEDS          = 3,
  parameter bit LED_ACTIVE_LOW  = 1'b1,
  parameter int BLINK_LOG2      = 21,
  parameter int SCAN_LOG2       = 20,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        dfu_state,
  input  logic              dfu_detach,
  input  logic              btn_boot,
  output logic              core_reset,
  output logic              usb_pull_en,
  output logic              boot_req,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        ctrl_state
);

  localparam int AB_CYCLES = CLK_HZ / 1000 * AUTOBOOT_MS;
  localparam bit AB_EN     = (AUTOBOOT_MS != 0);
  localparam int AB_W      = (AB_CYCLES > 0) ? $clog2(AB_CYCLES + 1) : 1;
  localparam int RST_W     = $clog2(RESET_CYCLES + 1);
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LC_W      = ((BLINK_LOG2 > SCAN_LOG2) ? BLINK_LOG2 : SCAN_LOG2) + 1;
  localparam int POS_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  typedef enum logic [1:0] {
    S_RST_HOLD = 2'd0,
    S_WAIT     = 2'd1,
    S_ACTIVE   = 2'd2,
    S_BOOT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q;
  logic [AB_W-1:0]    ab_cnt_q;
  logic               btn_s1_q, btn_s2_q;
  logic [DB_W-1:0]    db_cnt_q;
  logic               press_q;
  logic [LC_W-1:0]    led_cnt_q;
  logic [POS_W-1:0]   pos_q;
  logic               dir_down_q;
  logic               scan_tick;
  logic               blink;
  logic [N_LEDS-1:0]  led_log;

  assign scan_tick = &led_cnt_q[SCAN_LOG2-1:0];
  assign blink     = led_cnt_q[BLINK_LOG2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_RST_HOLD;
    else         state_q <= state_d;
  end

  // Boot triggers outrank the timeout, which outranks the hand-off to ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST_HOLD: if (rst_cnt_q == '0) state_d = S_WAIT;
      S_WAIT: begin
        if (dfu_detach || press_q)          state_d = S_BOOT;
        else if (AB_EN && ab_cnt_q == '0)   state_d = S_BOOT;
        else if (dfu_state > 8'h02)         state_d = S_ACTIVE;
      end
      S_ACTIVE: if (dfu_detach || press_q) state_d = S_BOOT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_cnt_q <= RST_W'(RESET_CYCLES - 1);
      ab_cnt_q  <= AB_W'(AB_CYCLES);
    end else begin
      if (state_q == S_RST_HOLD && rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - RST_W'(1);
      if (state_q != S_WAIT)    ab_cnt_q <= AB_W'(AB_CYCLES);
      else if (ab_cnt_q != '0)  ab_cnt_q <= ab_cnt_q - AB_W'(1);
    end
  end

  // Counter saturates at DEBOUNCE_CYCLES so a held button yields one press until released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      btn_s1_q <= btn_boot;
      btn_s2_q <= btn_s1_q;
      if (!btn_s2_q || state_q == S_RST_HOLD) begin
        db_cnt_q <= '0;
        press_q  <= 1'b0;
      end else begin
        press_q <= (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
        if (db_cnt_q != DB_W'(DEBOUNCE_CYCLES)) db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_cnt_q  <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
    end else begin
      led_cnt_q <= led_cnt_q + LC_W'(1);
      if (state_q == S_RST_HOLD || N_LEDS == 1) begin
        pos_q      <= '0;
        dir_down_q <= 1'b0;
      end else if (scan_tick) begin
        if (!dir_down_q) begin
          if (pos_q == POS_W'(N_LEDS - 1)) begin
            pos_q      <= pos_q - POS_W'(1);
            dir_down_q <= 1'b1;
          end else begin
            pos_q <= pos_q + POS_W'(1);
          end
        end else begin
          if (pos_q == '0) begin
            pos_q      <= POS_W'(1);
            dir_down_q <= 1'b0;
          end else begin
            pos_q <= pos_q - POS_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    led_log = '0;
    case (state_d)
      S_BOOT: led_log = '1;
      S_WAIT, S_ACTIVE: begin
        if (dfu_state == 8'h02)      led_log[0] = blink;
        else if (dfu_state == 8'h0A) led_log = {N_LEDS{blink}};
        else                         led_log = N_LEDS'(1) << pos_q;
      end
      default: led_log = '0;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_reset  <= 1'b1;
      usb_pull_en <= 1'b0;
      boot_req    <= 1'b0;
      led         <= {N_LEDS{LED_ACTIVE_LOW}};
      ctrl_state  <= S_RST_HOLD;
    end else begin
      core_reset  <= (state_d == S_RST_HOLD) || (state_d == S_BOOT);
      usb_pull_en <= (state_d == S_WAIT) || (state_d == S_ACTIVE);
      boot_req    <= (state_d == S_BOOT);
      led         <= led_log ^ {N_LEDS{LED_ACTIVE_LOW}};
      ctrl_state  <= state_d;
    end
  end

endmodule
